// File: rtl/iter_shifter_pkg.sv
// Shared shifter definitions: op encodings, FSM state encodings and widths.
// Used by iter_shifter, the combinational Shifter and the ALU decoder.
package shifter_defs;

    localparam int WIDTH = 32;
    localparam int AMT_W = 5;

    localparam logic [1:0] SHOP_SRL = 2'b00;
    localparam logic [1:0] SHOP_SRA = 2'b01;
    localparam logic [1:0] SHOP_SLL = 2'b10;
    localparam logic [1:0] SHOP_ROT = 2'b11;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_BUSY = 2'd1,
        S_DONE = 2'd2
    } state_t;

    // Bits needed to hold a per-cycle shift amount of 0..step.
    function automatic int step_bits(input int step);
        return $clog2(step + 1);
    endfunction

endpackage

// File: rtl/iter_shifter_if.sv
// Request/result handshake bundle for iter_shifter.
import shifter_defs::*;

interface iter_shifter_if;
    // A transfer happens on a rising clock edge where valid and ready are both
    // high; the sender holds valid and its payload stable until that edge.
    logic               in_valid;
    logic               in_ready;
    logic [WIDTH-1:0]   in_data;
    logic [1:0]         in_shiftop;
    logic [AMT_W-1:0]   in_shiftamt;
    logic               out_valid;
    logic               out_ready;
    logic [WIDTH-1:0]   out_result;

    modport master (
        output in_valid, in_data, in_shiftop, in_shiftamt, out_ready,
        input  in_ready, out_valid, out_result
    );

    modport slave (
        input  in_valid, in_data, in_shiftop, in_shiftamt, out_ready,
        output in_ready, out_valid, out_result
    );
endinterface

// File: rtl/iter_shifter_shift_step.sv
// Combinational single-step shifter: moves value by s (0..STEP) positions.
// Op 11 rotates right only when ITER_SHIFTER_ROTATE_EN is defined, else passes through.
import shifter_defs::*;

module shift_step #(
    parameter int STEP = 1,
    localparam int S_W = step_bits(STEP)
) (
    input  logic [WIDTH-1:0] value,
    input  logic [1:0]       op,
    input  logic [S_W-1:0]   s,
    output logic [WIDTH-1:0] next
);
    always_comb begin
        next = value;
        case (op)
            SHOP_SRL: next = value >> s;
            // Sign comes from the current working value, so it survives every step.
            SHOP_SRA: next = $signed(value) >>> s;
            SHOP_SLL: next = value << s;
`ifdef ITER_SHIFTER_ROTATE_EN
            SHOP_ROT: next = WIDTH'({value, value} >> s);
`else
            SHOP_ROT: next = value;
`endif
            default:  next = value;
        endcase
    end
endmodule

// File: rtl/iter_shifter.sv
// Multi-cycle SRL/SRA/SLL unit moving STEP bits per busy cycle (IDLE->BUSY->DONE).
// Optional rotate for op 11 under ITER_SHIFTER_ROTATE_EN.
import shifter_defs::*;

module iter_shifter #(
    parameter int STEP = 1
) (
    input  logic                 clock,
    input  logic                 reset,
    iter_shifter_if.slave        bus,
    output state_t               state_dbg
);
    localparam int S_W = step_bits(STEP);

    state_t             state_q, state_d;
    logic [WIDTH-1:0]   work_q, work_d;
    logic [WIDTH-1:0]   res_q, res_d;
    logic [1:0]         op_q, op_d;
    logic [AMT_W-1:0]   rem_q, rem_d;
    logic [S_W-1:0]     step_amt;
    logic [WIDTH-1:0]   step_out;

    always_comb begin
        step_amt = S_W'(STEP);
        if (rem_q < AMT_W'(STEP))
            step_amt = S_W'(rem_q);
    end

    shift_step #(.STEP(STEP)) u_step (
        .value (work_q),
        .op    (op_q),
        .s     (step_amt),
        .next  (step_out)
    );

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q <= S_IDLE;
            work_q  <= '0;
            res_q   <= '0;
            op_q    <= SHOP_SRL;
            rem_q   <= '0;
        end else begin
            state_q <= state_d;
            work_q  <= work_d;
            res_q   <= res_d;
            op_q    <= op_d;
            rem_q   <= rem_d;
        end
    end

    always_comb begin
        state_d = state_q;
        work_d  = work_q;
        res_d   = res_q;
        op_d    = op_q;
        rem_d   = rem_q;
        case (state_q)
            S_IDLE: begin
                if (bus.in_valid) begin
                    work_d = bus.in_data;
                    op_d   = bus.in_shiftop;
                    rem_d  = bus.in_shiftamt;
                    if (bus.in_shiftamt == '0) begin
                        res_d   = bus.in_data;
                        state_d = S_DONE;
                    end else begin
                        state_d = S_BUSY;
                    end
                end
            end
            S_BUSY: begin
                work_d = step_out;
                rem_d  = rem_q - AMT_W'(step_amt);
                if (rem_d == '0) begin
                    res_d   = step_out;
                    state_d = S_DONE;
                end
            end
            S_DONE: begin
                // The result register is left alone so out_result keeps its value in IDLE.
                if (bus.out_ready)
                    state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    assign bus.in_ready   = (state_q == S_IDLE);
    assign bus.out_valid  = (state_q == S_DONE);
    assign bus.out_result = res_q;
    assign state_dbg      = state_q;

endmodule

// File: tb/tb_iter_shifter.sv
// Directed bench for iter_shifter: one instance with STEP=1 and one with STEP=4.
// Expected values are hand-computed or come from a plain >>, >>>, << reference.
import shifter_defs::*;

module tb_iter_shifter;

    logic clock;
    logic reset;
    state_t st1, st4;
    int n_vec;
    int n_err;

    iter_shifter_if if1 ();
    iter_shifter_if if4 ();

    iter_shifter #(.STEP(1)) dut1 (.clock(clock), .reset(reset), .bus(if1.slave), .state_dbg(st1));
    iter_shifter #(.STEP(4)) dut4 (.clock(clock), .reset(reset), .bus(if4.slave), .state_dbg(st4));

    // clock / reset
    initial begin
        clock = 1'b0;
        forever #5 clock = ~clock;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %08h expected %08h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] ref_shift(input logic [31:0] d, input logic [1:0] op, input int amt);
        logic [31:0] r;
        case (op)
            2'b00: r = d >> amt;
            2'b01: r = $signed(d) >>> amt;
            2'b10: r = d << amt;
`ifdef ITER_SHIFTER_ROTATE_EN
            default: r = (amt == 0) ? d : ((d >> amt) | (d << (32 - amt)));
`else
            default: r = d;
`endif
        endcase
        return r;
    endfunction

    // driver tasks
    task automatic set_req(input int sel, input logic v, input logic [31:0] d, input logic [1:0] op,
                           input logic [4:0] amt);
        if (sel == 1) begin
            if1.in_valid = v; if1.in_data = d; if1.in_shiftop = op; if1.in_shiftamt = amt;
        end else begin
            if4.in_valid = v; if4.in_data = d; if4.in_shiftop = op; if4.in_shiftamt = amt;
        end
    endtask

    task automatic set_out_ready(input int sel, input logic r);
        if (sel == 1) if1.out_ready = r;
        else          if4.out_ready = r;
    endtask

    function automatic logic get_in_ready(input int sel);
        return (sel == 1) ? if1.in_ready : if4.in_ready;
    endfunction

    function automatic logic get_out_valid(input int sel);
        return (sel == 1) ? if1.out_valid : if4.out_valid;
    endfunction

    function automatic logic [31:0] get_out_result(input int sel);
        return (sel == 1) ? if1.out_result : if4.out_result;
    endfunction

    // Accept a request, count edges until out_valid, then complete the result handshake.
    task automatic run_op(input int sel, input logic [31:0] d, input logic [1:0] op, input logic [4:0] amt,
                          output logic [31:0] res, output int lat);
        int wait_n;
        wait_n = 0;
        while (!get_in_ready(sel) && wait_n < 50) begin
            @(posedge clock); #1; wait_n++;
        end
        if (wait_n >= 50) check("in_ready_timeout", 32'(get_in_ready(sel)), 32'd1);
        set_req(sel, 1'b1, d, op, amt);
        @(posedge clock); #1;
        set_req(sel, 1'b0, 32'h0, 2'b00, 5'd0);
        lat = 0;
        while (!get_out_valid(sel) && lat < 100) begin
            check("in_ready_busy", 32'(get_in_ready(sel)), 32'd0);
            @(posedge clock); #1; lat++;
        end
        if (lat >= 100) check("out_valid_timeout", 32'(get_out_valid(sel)), 32'd1);
        check("in_ready_done", 32'(get_in_ready(sel)), 32'd0);
        res = get_out_result(sel);
        set_out_ready(sel, 1'b1);
        @(posedge clock); #1;
        set_out_ready(sel, 1'b0);
        check("out_valid_drop", 32'(get_out_valid(sel)), 32'd0);
        check("result_hold", get_out_result(sel), res);
    endtask

    task automatic op_check(input string tag, input int sel, input logic [31:0] d, input logic [1:0] op,
                            input logic [4:0] amt, input logic [31:0] exp);
        logic [31:0] res;
        int lat;
        int step;
        step = (sel == 1) ? 1 : 4;
        run_op(sel, d, op, amt, res, lat);
        check(tag, res, exp);
        check({tag, "_lat"}, 32'(lat), 32'((int'(amt) + step - 1) / step));
    endtask

    logic [31:0] sweep_ops4 [8];
    logic [31:0] sweep_ops1 [2];

    initial begin
        n_vec = 0;
        n_err = 0;
        reset = 1'b1;
        set_req(1, 1'b0, 32'h0, 2'b00, 5'd0);
        set_req(4, 1'b0, 32'h0, 2'b00, 5'd0);
        if1.out_ready = 1'b0;
        if4.out_ready = 1'b0;
        repeat (3) @(posedge clock);
        #1 reset = 1'b0;

        check("rst_in_ready1", 32'(if1.in_ready), 32'd1);
        check("rst_out_valid1", 32'(if1.out_valid), 32'd0);
        check("rst_result1", if1.out_result, 32'h0);
        check("rst_state1", 32'(st1), 32'(S_IDLE));
        check("rst_in_ready4", 32'(if4.in_ready), 32'd1);
        check("rst_out_valid4", 32'(if4.out_valid), 32'd0);
        check("rst_result4", if4.out_result, 32'h0);

        op_check("sra_step1", 1, 32'h8000_00F0, SHOP_SRA, 5'd4, 32'hF800_000F);
        op_check("sll_step4", 4, 32'h0000_0001, SHOP_SLL, 5'd31, 32'h8000_0000);
        op_check("srl_step4", 4, 32'h0000_0001, SHOP_SRL, 5'd31, 32'h0000_0000);
        op_check("sra_step4_31", 4, 32'h8000_0000, SHOP_SRA, 5'd31, 32'hFFFF_FFFF);
        op_check("srl_step4_5", 4, 32'hF000_000F, SHOP_SRL, 5'd5, 32'h0780_0000);
        for (int op = 0; op < 4; op++) begin
            op_check("amt0_step4", 4, 32'hDEAD_BEEF, 2'(op), 5'd0, 32'hDEAD_BEEF);
            op_check("amt0_step1", 1, 32'hDEAD_BEEF, 2'(op), 5'd0, 32'hDEAD_BEEF);
        end
`ifdef ITER_SHIFTER_ROTATE_EN
        op_check("rot_1", 1, 32'h0000_0001, SHOP_ROT, 5'd1, 32'h8000_0000);
        op_check("rot_4_step4", 4, 32'h0000_00F1, SHOP_ROT, 5'd4, 32'h1000_000F);
`else
        op_check("pass_op11", 4, 32'hDEAD_BEEF, SHOP_ROT, 5'd5, 32'hDEAD_BEEF);
        op_check("pass_op11_s1", 1, 32'h1234_5678, SHOP_ROT, 5'd3, 32'h1234_5678);
`endif

        // Backpressure: result held for 5 cycles while in_valid is pulsed.
        begin
            int w;
            set_req(1, 1'b1, 32'h0000_0001, SHOP_SLL, 5'd3);
            @(posedge clock); #1;
            set_req(1, 1'b0, 32'h0, 2'b00, 5'd0);
            w = 0;
            while (!if1.out_valid && w < 50) begin
                @(posedge clock); #1; w++;
            end
            check("bp_latency", 32'(w), 32'd3);
            for (int c = 0; c < 5; c++) begin
                check("bp_out_valid", 32'(if1.out_valid), 32'd1);
                check("bp_result", if1.out_result, 32'h0000_0008);
                check("bp_in_ready", 32'(if1.in_ready), 32'd0);
                set_req(1, (c % 2) == 0, 32'h0000_FFFF, SHOP_SRL, 5'd0);
                @(posedge clock); #1;
            end
            set_req(1, 1'b0, 32'h0, 2'b00, 5'd0);
            if1.out_ready = 1'b1;
            @(posedge clock); #1;
            if1.out_ready = 1'b0;
            check("bp_valid_drop", 32'(if1.out_valid), 32'd0);
            check("bp_in_ready_back", 32'(if1.in_ready), 32'd1);
            check("bp_result_kept", if1.out_result, 32'h0000_0008);
            @(posedge clock); #1;
            check("bp_no_accept", 32'(st1), 32'(S_IDLE));
        end

        // Reset at edge 7 of a 20-step SRL.
        set_req(1, 1'b1, 32'hFFFF_FFFF, SHOP_SRL, 5'd20);
        @(posedge clock); #1;
        set_req(1, 1'b0, 32'h0, 2'b00, 5'd0);
        repeat (6) begin
            @(posedge clock); #1;
        end
        check("midbusy_state", 32'(st1), 32'(S_BUSY));
        reset = 1'b1;
        @(posedge clock); #1;
        reset = 1'b0;
        check("abort_state", 32'(st1), 32'(S_IDLE));
        check("abort_out_valid", 32'(if1.out_valid), 32'd0);
        check("abort_result", if1.out_result, 32'h0);
        check("abort_in_ready", 32'(if1.in_ready), 32'd1);
        op_check("after_abort", 1, 32'hFFFF_FFFF, SHOP_SRL, 5'd1, 32'h7FFF_FFFF);

        // Sweep of amounts and ops against the reference shifts.
        sweep_ops4 = '{32'h0000_0000, 32'h0000_0001, 32'h0000_FFFF, 32'h0000_8001,
                       32'h8000_0000, 32'h8000_FFFF, 32'h8000_5A5A, 32'h0000_A5A5};
        sweep_ops1 = '{32'h8000_00F1, 32'h0000_7FFF};
        foreach (sweep_ops4[i])
            for (int op = 0; op < 4; op++)
                for (int a = 0; a < 32; a++)
                    op_check("sweep4", 4, sweep_ops4[i], 2'(op), 5'(a), ref_shift(sweep_ops4[i], 2'(op), a));
        foreach (sweep_ops1[i])
            for (int op = 0; op < 4; op++)
                for (int a = 0; a < 32; a++)
                    op_check("sweep1", 1, sweep_ops1[i], 2'(op), 5'(a), ref_shift(sweep_ops1[i], 2'(op), a));

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
